alu_nibble_sequencer: RTL and testbench
=======================================

# alu_nibble_sequencer

Upstream operand-entry stage for the 4-bit ALU. Collects opcode, operand A and operand B as successive 4-bit nibbles from the input switches, each qualified by a one-cycle strobe. Holds them in registers that drive the ALU's combinational inputs, then captures the ALU result and Z/C flags into output registers for the LED stage. Provides a ready/valid handshake, an optional partial-entry timeout and an optional result-chaining mode.

## Interface
- TIMEOUT_CYCLES, default 0: idle cycles allowed in LOAD_A/LOAD_B before the entry is abandoned; 0 disables the timeout.
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- nib_in  in  4  nibble data from the switches.
- nib_valid  in  1  one-cycle strobe; nib_in is accepted on a rising edge where nib_valid && nib_ready.
- nib_ready  out  1  high in LOAD_OP, LOAD_A, LOAD_B and HOLD; low in EXEC. Decoded from state.
- alu_op  out  4  registered opcode to the ALU.
- alu_a  out  4  registered operand A to the ALU.
- alu_b  out  4  registered operand B to the ALU.
- alu_res  in  4  combinational ALU result.
- alu_z  in  1  ALU zero flag.
- alu_c  in  1  ALU carry flag.
- res_out  out  4  captured result.
- res_z  out  1  captured zero flag.
- res_c  out  1  captured carry flag.
- res_valid  out  1  high while res_out, res_z and res_c hold a result for the current alu_* registers.
- entry_abort  out  1  one-cycle pulse when a timeout abandons a partial entry.

## Operation
- States: LOAD_OP, LOAD_A, LOAD_B, EXEC, HOLD. Reset state is LOAD_OP.
- LOAD_OP: on accept, alu_op <= nib_in and the state moves to LOAD_A.
- LOAD_A: on accept, alu_a <= nib_in and the state moves to LOAD_B.
- LOAD_B: on accept, alu_b <= nib_in and the state moves to EXEC.
- EXEC: lasts exactly one cycle, which lets the ALU settle. At its closing edge: res_out <= alu_res, res_z <= alu_z, res_c <= alu_c, res_valid <= 1, and the state moves to HOLD.
- HOLD: alu_* and res_* are held stable. On accept, alu_op <= nib_in, res_valid <= 0, and the state moves to LOAD_A (or to LOAD_B in chain mode, see Configuration). res_out, res_z and res_c keep their old values until the next capture.
- A nib_valid in EXEC is dropped. It is not buffered.
- Timeout applies only when TIMEOUT_CYCLES > 0.
  - Counter width: max(1, $clog2(TIMEOUT_CYCLES+1)).
  - The counter clears on every accepted nibble and in any state other than LOAD_A/LOAD_B.
  - It increments each cycle spent in LOAD_A or LOAD_B without an accept.
  - At the edge where the counter equals TIMEOUT_CYCLES-1 with no accept: the state moves to LOAD_OP, entry_abort pulses for the following cycle, and alu_* keep their stale values.
  - An accept on that same edge wins; no abort occurs.
- Reset forces every output register to 0 (alu_op, alu_a, alu_b, res_out, res_z, res_c, res_valid, entry_abort), clears the counter and sets the state to LOAD_OP. Because nib_ready is decoded from LOAD_OP, it reads 1 during reset.
- Reset mid-entry discards all partial data.

## Timing
- Register updates occur only on the rising clk edge where acceptance happens.
- Edge E accepts B → state is EXEC in cycle E..E+1 → at edge E+1 the result is captured and res_valid rises. Latency from B acceptance to res_valid is 1 cycle.
- Minimum full transaction: 3 accepts plus 1 EXEC cycle = 4 cycles from the first accept to res_valid.
- Back-to-back: a new opcode may be accepted in the first HOLD cycle.
- No combinational path from nib_in or nib_valid to any output except through the state register.

## Configuration
- ALU_SEQ_CHAIN_EN
  - Defined: an opcode accepted in HOLD also loads alu_a <= res_out on the same edge, and the state moves straight to LOAD_B. Only two nibbles are needed per chained operation. An opcode accepted in LOAD_OP (after reset or abort) always goes to LOAD_A.
  - Undefined: an opcode accepted in HOLD always goes to LOAD_A and res_out is never fed back.

## Structure
- Package alu_seq_pkg holds:
  - the state enum (3-bit encoding, LOAD_OP = 0);
  - the NIB_W = 4 constant;
  - opcode-group constants matching the ALU map: SHIFT 0000–0011, ARITH 0100–0111, LOGIC 1000–1011, COMPARE 1100–1111.
- One sub-module, alu_seq_timeout, contains the parameterised idle counter and the abort pulse generator. It is instantiated only when TIMEOUT_CYCLES > 0, via generate.

## Test plan
- Reset, then strobes 0100, 0011, 0101 (ADD 3+5) → res_out=1000, res_z=0, res_c=0; res_valid rises 1 cycle after the B accept.
- SUB: 0110, 0101, 0101 → res_out=0000, res_z=1, res_c=1; nib_ready=0 during the EXEC cycle only.
- nib_valid pulsed with 1111 during EXEC → ignored; the next accept in HOLD loads alu_op=the new nibble, not 1111.
- TIMEOUT_CYCLES=8: opcode and A accepted, then idle → entry_abort pulses exactly once, 8 cycles after the A accept; state returns to LOAD_OP; a nib_valid on the abort edge is accepted instead.
- ALU_SEQ_CHAIN_EN defined: ADD 3+5 completes, then in HOLD strobes 0100 and 0001 → alu_a=1000, res_out=1001. With the macro undefined, the same strobes leave the block in LOAD_B with alu_a=0001 and res_valid=0.
- rst asserted for 1 cycle after the A accept → all outputs 0, nib_ready=1, state LOAD_OP; a fresh 3-nibble entry then completes normally.

Source files
------------

// File: rtl/alu_nibble_sequencer_pkg.sv
// Shared types and constants for the ALU operand-entry sequencer.
// Opcode groups mirror the downstream 4-bit ALU opcode map.
package alu_seq_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [2:0] {
      ST_LOAD_OP = 3'd0,
      ST_LOAD_A  = 3'd1,
      ST_LOAD_B  = 3'd2,
      ST_EXEC    = 3'd3,
      ST_HOLD    = 3'd4
   } seq_state_t;

   localparam logic [1:0] GRP_SHIFT   = 2'b00;
   localparam logic [1:0] GRP_ARITH   = 2'b01;
   localparam logic [1:0] GRP_LOGIC   = 2'b10;
   localparam logic [1:0] GRP_COMPARE = 2'b11;

   function automatic logic [1:0] op_group(input logic [NIB_W-1:0] op);
      return op[NIB_W-1 -: 2];
   endfunction

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// Nibble entry, ALU operand/result and LED-stage signals of the sequencer.
// slave = sequencer side, master = switches/ALU/LED side.
interface alu_nibble_sequencer_if;
   import alu_seq_pkg::*;

   logic [NIB_W-1:0] nib_in;
   logic             nib_valid;
   logic             nib_ready;
   logic [NIB_W-1:0] alu_op;
   logic [NIB_W-1:0] alu_a;
   logic [NIB_W-1:0] alu_b;
   logic [NIB_W-1:0] alu_res;
   logic             alu_z;
   logic             alu_c;
   logic [NIB_W-1:0] res_out;
   logic             res_z;
   logic             res_c;
   logic             res_valid;
   logic             entry_abort;

   modport slave (
      input  nib_in, nib_valid, alu_res, alu_z, alu_c,
      output nib_ready, alu_op, alu_a, alu_b,
             res_out, res_z, res_c, res_valid, entry_abort
   );

   modport master (
      output nib_in, nib_valid, alu_res, alu_z, alu_c,
      input  nib_ready, alu_op, alu_a, alu_b,
             res_out, res_z, res_c, res_valid, entry_abort
   );

endinterface

// File: rtl/alu_nibble_sequencer_timeout.sv
// Idle counter for partial operand entry: o_expire flags the abandoning edge,
// o_abort is the registered one-cycle pulse that follows it.
module alu_seq_timeout #(
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic i_active,
   input  logic i_accept,
   output logic o_expire,
   output logic o_abort
);

   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_abort;

   // An accept on the terminal edge suppresses the expiry.
   assign o_expire = i_active && !i_accept && (r_cnt == LAST_CNT);
   assign o_abort  = r_abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_abort <= 1'b0;
      end else begin
         if (!i_active || i_accept || o_expire) r_cnt <= '0;
         else                                  r_cnt <= r_cnt + CNT_W'(1);
         r_abort <= o_expire;
      end
   end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Collects opcode/A/B nibbles for the 4-bit ALU and registers its result.
// Optional feature macro: ALU_SEQ_CHAIN_EN (HOLD opcode reuses res_out as A).
//
// state      | meaning
// LOAD_OP    | waiting for opcode nibble
// LOAD_A     | waiting for operand A
// LOAD_B     | waiting for operand B
// EXEC       | one settle cycle for the ALU; strobes dropped
// HOLD       | result valid; next opcode accepted
module alu_nibble_sequencer
   import alu_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   alu_nibble_sequencer_if.slave bus
);

   seq_state_t       r_state, w_next_state;
   logic [NIB_W-1:0] r_alu_op, r_alu_a, r_alu_b, r_res_out;
   logic             r_res_z, r_res_c, r_res_valid;

   logic w_ready, w_accept, w_expire, w_abort;
   logic w_load_op, w_load_a, w_load_b, w_chain_a, w_capture, w_clr_valid;

   assign w_ready  = (r_state != ST_EXEC);
   assign w_accept = bus.nib_valid && w_ready;

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timeout
         alu_seq_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
            .clk      (clk),
            .rst      (rst),
            .i_active ((r_state == ST_LOAD_A) || (r_state == ST_LOAD_B)),
            .i_accept (w_accept),
            .o_expire (w_expire),
            .o_abort  (w_abort)
         );
      end else begin : g_no_timeout
         assign w_expire = 1'b0;
         assign w_abort  = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_LOAD_OP;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_load_op    = 1'b0;
      w_load_a     = 1'b0;
      w_load_b     = 1'b0;
      w_chain_a    = 1'b0;
      w_capture    = 1'b0;
      w_clr_valid  = 1'b0;
      case (r_state)
         ST_LOAD_OP: begin
            if (w_accept) begin
               w_load_op    = 1'b1;
               w_next_state = ST_LOAD_A;
            end
         end
         ST_LOAD_A: begin
            if (w_accept) begin
               w_load_a     = 1'b1;
               w_next_state = ST_LOAD_B;
            end else if (w_expire) begin
               w_next_state = ST_LOAD_OP;
            end
         end
         ST_LOAD_B: begin
            if (w_accept) begin
               w_load_b     = 1'b1;
               w_next_state = ST_EXEC;
            end else if (w_expire) begin
               w_next_state = ST_LOAD_OP;
            end
         end
         ST_EXEC: begin
            w_capture    = 1'b1;
            w_next_state = ST_HOLD;
         end
         ST_HOLD: begin
            if (w_accept) begin
               w_load_op   = 1'b1;
               w_clr_valid = 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
               w_chain_a    = 1'b1;
               w_next_state = ST_LOAD_B;
`else
               w_next_state = ST_LOAD_A;
`endif
            end
         end
         default: w_next_state = ST_LOAD_OP;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_op    <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_res_out   <= '0;
         r_res_z     <= 1'b0;
         r_res_c     <= 1'b0;
         r_res_valid <= 1'b0;
      end else begin
         if (w_load_op) r_alu_op <= bus.nib_in;
         if (w_load_a)       r_alu_a <= bus.nib_in;
         else if (w_chain_a) r_alu_a <= r_res_out;
         if (w_load_b) r_alu_b <= bus.nib_in;
         if (w_capture) begin
            r_res_out   <= bus.alu_res;
            r_res_z     <= bus.alu_z;
            r_res_c     <= bus.alu_c;
            r_res_valid <= 1'b1;
         end else if (w_clr_valid) begin
            r_res_valid <= 1'b0;
         end
      end
   end

   assign bus.nib_ready   = w_ready;
   assign bus.alu_op      = r_alu_op;
   assign bus.alu_a       = r_alu_a;
   assign bus.alu_b       = r_alu_b;
   assign bus.res_out     = r_res_out;
   assign bus.res_z       = r_res_z;
   assign bus.res_c       = r_res_c;
   assign bus.res_valid   = r_res_valid;
   assign bus.entry_abort = w_abort;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer with a small behavioural ALU;
// expectations follow ALU_SEQ_CHAIN_EN when it is defined.
module tb_alu_nibble_sequencer;
   import alu_seq_pkg::*;

   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vecs = 0;
   int   errs = 0;

   alu_nibble_sequencer_if bus ();

   alu_nibble_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ALU model: 0100 ADD, 0110 SUB (carry = no borrow), logic group AND, else XOR.
   logic [4:0] alu_sum;
   always_comb begin
      alu_sum = 5'd0;
      if (bus.alu_op == 4'b0100)
         alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      else if (bus.alu_op == 4'b0110)
         alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 5'd1;
      else if (op_group(bus.alu_op) == GRP_LOGIC)
         alu_sum = {1'b0, bus.alu_a & bus.alu_b};
      else
         alu_sum = {1'b0, bus.alu_a ^ bus.alu_b};
   end
   assign bus.alu_res = alu_sum[3:0];
   assign bus.alu_c   = alu_sum[4];
   assign bus.alu_z   = (alu_sum[3:0] == 4'd0);

   // Caller sits at a negedge; strobe is sampled on the next posedge.
   task automatic send(input logic [3:0] n);
      bus.nib_in    = n;
      bus.nib_valid = 1'b1;
      @(negedge clk);
      bus.nib_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.nib_valid = 1'b0;
      bus.nib_in    = 4'd0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [20:0] obs;
      bus.nib_valid = 1'b0;
      bus.nib_in    = 4'd0;
      @(negedge clk);
      obs = {bus.alu_op, bus.alu_a, bus.alu_b, bus.res_out, bus.res_z, bus.res_c,
             bus.res_valid, bus.entry_abort, bus.nib_ready};
      vecs++;
      if (obs !== 21'h000001) begin
         $display("FAIL reset_outputs: got %h expected %h", obs, 21'h000001);
         errs++;
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add();
      do_reset();
      send(4'b0100);
      send(4'b0011);
      send(4'b0101);
      vecs++;
      if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 12'h435) begin
         $display("FAIL add_operands: got %h expected %h", {bus.alu_op, bus.alu_a, bus.alu_b}, 12'h435);
         errs++;
      end
      vecs++;
      if ({bus.nib_ready, bus.res_valid} !== 2'b00) begin
         $display("FAIL add_exec_flags: got %b expected %b", {bus.nib_ready, bus.res_valid}, 2'b00);
         errs++;
      end
      @(negedge clk);
      vecs++;
      if ({bus.res_out, bus.res_z, bus.res_c, bus.res_valid, bus.nib_ready} !== 8'b1000_0011) begin
         $display("FAIL add_result: got %b expected %b",
                  {bus.res_out, bus.res_z, bus.res_c, bus.res_valid, bus.nib_ready}, 8'b1000_0011);
         errs++;
      end
   endtask

   task automatic test_sub();
      do_reset();
      send(4'b0110);
      vecs++;
      if (bus.nib_ready !== 1'b1) begin
         $display("FAIL sub_ready_load_a: got %b expected 1", bus.nib_ready);
         errs++;
      end
      send(4'b0101);
      vecs++;
      if (bus.nib_ready !== 1'b1) begin
         $display("FAIL sub_ready_load_b: got %b expected 1", bus.nib_ready);
         errs++;
      end
      send(4'b0101);
      vecs++;
      if (bus.nib_ready !== 1'b0) begin
         $display("FAIL sub_ready_exec: got %b expected 0", bus.nib_ready);
         errs++;
      end
      @(negedge clk);
      vecs++;
      if ({bus.res_out, bus.res_z, bus.res_c, bus.res_valid, bus.nib_ready} !== 8'b0000_1111) begin
         $display("FAIL sub_result: got %b expected %b",
                  {bus.res_out, bus.res_z, bus.res_c, bus.res_valid, bus.nib_ready}, 8'b0000_1111);
         errs++;
      end
   endtask

   task automatic test_exec_drop();
      do_reset();
      send(4'b0100);
      send(4'b0001);
      send(4'b0010);
      bus.nib_in    = 4'b1111;
      bus.nib_valid = 1'b1;
      @(negedge clk);
      bus.nib_valid = 1'b0;
      vecs++;
      if ({bus.alu_op, bus.res_out, bus.res_valid} !== 9'b0100_0011_1) begin
         $display("FAIL exec_drop_hold: got %b expected %b",
                  {bus.alu_op, bus.res_out, bus.res_valid}, 9'b0100_0011_1);
         errs++;
      end
      send(4'b0110);
      vecs++;
      if ({bus.alu_op, bus.res_out, bus.res_valid} !== 9'b0110_0011_0) begin
         $display("FAIL exec_drop_next_op: got %b expected %b",
                  {bus.alu_op, bus.res_out, bus.res_valid}, 9'b0110_0011_0);
         errs++;
      end
   endtask

   task automatic test_timeout();
      int pulses;
      do_reset();
      send(4'b0100);
      send(4'b0011);
      pulses = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.entry_abort === 1'b1) pulses++;
         if (k == 8) begin
            vecs++;
            if (bus.entry_abort !== 1'b1) begin
               $display("FAIL timeout_abort_cycle: got %b expected 1", bus.entry_abort);
               errs++;
            end
            vecs++;
            if ({bus.alu_op, bus.alu_a} !== 8'h43) begin
               $display("FAIL timeout_stale_regs: got %h expected %h", {bus.alu_op, bus.alu_a}, 8'h43);
               errs++;
            end
         end
      end
      vecs++;
      if (pulses !== 1) begin
         $display("FAIL timeout_pulse_count: got %0d expected 1", pulses);
         errs++;
      end
      send(4'b0110);
      vecs++;
      if ({bus.alu_op, bus.alu_a} !== 8'h63) begin
         $display("FAIL timeout_back_to_load_op: got %h expected %h", {bus.alu_op, bus.alu_a}, 8'h63);
         errs++;
      end
      send(4'b0101);
      send(4'b0101);
      @(negedge clk);
      vecs++;
      if ({bus.res_out, bus.res_z, bus.res_c, bus.res_valid} !== 7'b0000_111) begin
         $display("FAIL timeout_recover_result: got %b expected %b",
                  {bus.res_out, bus.res_z, bus.res_c, bus.res_valid}, 7'b0000_111);
         errs++;
      end
   endtask

   task automatic test_timeout_accept_wins();
      int pulses;
      do_reset();
      send(4'b0100);
      send(4'b0011);
      for (int k = 1; k <= 7; k++) @(negedge clk);
      send(4'b0010);
      pulses = (bus.entry_abort === 1'b1) ? 1 : 0;
      vecs++;
      if ({bus.alu_b, bus.nib_ready} !== 5'b0010_0) begin
         $display("FAIL accept_wins_b_loaded: got %b expected %b", {bus.alu_b, bus.nib_ready}, 5'b0010_0);
         errs++;
      end
      @(negedge clk);
      if (bus.entry_abort === 1'b1) pulses++;
      vecs++;
      if (pulses !== 0) begin
         $display("FAIL accept_wins_no_abort: got %0d pulses expected 0", pulses);
         errs++;
      end
      vecs++;
      if ({bus.res_out, bus.res_valid} !== 5'b0101_1) begin
         $display("FAIL accept_wins_result: got %b expected %b", {bus.res_out, bus.res_valid}, 5'b0101_1);
         errs++;
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      send(4'b0100);
      send(4'b0011);
      send(4'b0101);
      @(negedge clk);
      send(4'b0100);
      send(4'b0001);
`ifdef ALU_SEQ_CHAIN_EN
      vecs++;
      if ({bus.alu_a, bus.alu_b, bus.nib_ready} !== 9'b1000_0001_0) begin
         $display("FAIL chain_operands: got %b expected %b",
                  {bus.alu_a, bus.alu_b, bus.nib_ready}, 9'b1000_0001_0);
         errs++;
      end
      @(negedge clk);
      vecs++;
      if ({bus.res_out, bus.res_valid} !== 5'b1001_1) begin
         $display("FAIL chain_result: got %b expected %b", {bus.res_out, bus.res_valid}, 5'b1001_1);
         errs++;
      end
`else
      vecs++;
      if ({bus.alu_op, bus.alu_a, bus.res_valid, bus.nib_ready} !== 10'b0100_0001_0_1) begin
         $display("FAIL nochain_load_b: got %b expected %b",
                  {bus.alu_op, bus.alu_a, bus.res_valid, bus.nib_ready}, 10'b0100_0001_0_1);
         errs++;
      end
      vecs++;
      if (bus.res_out !== 4'b1000) begin
         $display("FAIL nochain_res_kept: got %b expected %b", bus.res_out, 4'b1000);
         errs++;
      end
      send(4'b0010);
      @(negedge clk);
      vecs++;
      if ({bus.res_out, bus.res_valid} !== 5'b0011_1) begin
         $display("FAIL nochain_result: got %b expected %b", {bus.res_out, bus.res_valid}, 5'b0011_1);
         errs++;
      end
`endif
   endtask

   task automatic test_reset_mid_entry();
      logic [20:0] obs;
      do_reset();
      send(4'b0100);
      send(4'b0011);
      rst = 1'b1;
      #1;
      obs = {bus.alu_op, bus.alu_a, bus.alu_b, bus.res_out, bus.res_z, bus.res_c,
             bus.res_valid, bus.entry_abort, bus.nib_ready};
      vecs++;
      if (obs !== 21'h000001) begin
         $display("FAIL mid_reset_outputs: got %h expected %h", obs, 21'h000001);
         errs++;
      end
      @(negedge clk);
      rst = 1'b0;
      send(4'b0100);
      send(4'b0011);
      send(4'b0101);
      vecs++;
      if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 12'h435) begin
         $display("FAIL mid_reset_operands: got %h expected %h", {bus.alu_op, bus.alu_a, bus.alu_b}, 12'h435);
         errs++;
      end
      @(negedge clk);
      vecs++;
      if ({bus.res_out, bus.res_valid} !== 5'b1000_1) begin
         $display("FAIL mid_reset_result: got %b expected %b", {bus.res_out, bus.res_valid}, 5'b1000_1);
         errs++;
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_exec_drop();
      test_timeout();
      test_timeout_accept_wins();
      test_back_to_back();
      test_reset_mid_entry();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
